// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-level round-robin arbiter sharing one uart_tx among NUM_REQ byte streams
//
// Optional feature macro: UART_TX_ARB_HEADER_EN
//   When defined, every grant starts with a header byte {4'hA, grant_id} before the packet bytes.
//
// Ports:
//   ser_clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready
//                             per-requester byte stream; requester i uses req_data[8i+7:8i]
//   tx_data, tx_req           byte and request towards uart_tx
//   tx_cts, tx_idle           uart_tx clear-to-send (byte taken when tx_req && tx_cts) and line idle
//   grant_valid, grant_id     current owner of the UART
//   busy                      grant_valid || !tx_idle
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 64
) (
    input  logic                       ser_clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_req,
    input  logic                       tx_cts,
    input  logic                       tx_idle,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef UART_TX_ARB_HEADER_EN
        , HDR = 2'd2
`endif
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_grant, last_grant_nxt;
    logic [IDW-1:0] grant_id_nxt;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] rr_idx;
    logic [7:0]     byte_cnt, byte_cnt_nxt;
    logic           sel_valid;
    logic           sel_last;
    logic [7:0]     sel_data;

    // Round-robin pick: scan from the farthest candidate back to the nearest so
    // the requester closest after last_grant overwrites any earlier match.
    always_comb begin
        winner = '0;
        rr_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[rr_idx]) begin
                winner = rr_idx;
            end
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[{grant_id, 3'b000} +: 8];

    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        byte_cnt_nxt   = byte_cnt;
        tx_req         = 1'b0;
        tx_data        = 8'h00;
        req_ready      = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_nxt = winner;
                    byte_cnt_nxt = 8'h00;
`ifdef UART_TX_ARB_HEADER_EN
                    state_nxt    = HDR;
`else
                    state_nxt    = SEND;
`endif
                end
            end
`ifdef UART_TX_ARB_HEADER_EN
            HDR: begin
                tx_req  = 1'b1;
                tx_data = {4'hA, 4'(grant_id)};
                if (tx_cts) begin
                    state_nxt = SEND;
                end
            end
`endif
            SEND: begin
                tx_req              = sel_valid;
                tx_data             = sel_valid ? sel_data : 8'h00;
                req_ready[grant_id] = tx_cts;
                if (sel_valid && tx_cts) begin
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    // Release on end of packet or when the length cap is reached.
                    if (sel_last || ((byte_cnt + 8'd1) == 8'(MAX_LEN))) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant_id;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            byte_cnt   <= 8'h00;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            byte_cnt   <= byte_cnt_nxt;
        end
    end

    assign grant_valid = (state != IDLE);
    assign busy        = grant_valid || !tx_idle;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb with a packet-level reference model
module tb_uart_tx_arb;
    localparam int NUM_REQ = 4;
    localparam int MAX_LEN = 64;
    localparam int IDW     = 2;
`ifdef UART_TX_ARB_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic                 ser_clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_req;
    logic                 tx_cts;
    logic                 tx_idle;
    logic                 grant_valid;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN)) dut (
        .ser_clk    (ser_clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_cts     (tx_cts),
        .tx_idle    (tx_idle),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t              src_q[NUM_REQ][$];
    beat_t              exp_q[NUM_REQ][$];
    int                 errors = 0;
    int                 checks = 0;
    int                 cts_mode = 3;
    bit                 gap_en = 1'b0;
    int                 cyc = 0;
    int                 m_owner = -1;
    int                 m_last = NUM_REQ - 1;
    int                 m_cnt = 0;
    bit                 m_hdr = 1'b0;
    int                 grant_log[$];
    logic [7:0]         tx_log[$];
    int                 rdy_cnt[NUM_REQ];
    logic [NUM_REQ-1:0] acc;

    initial begin
        ser_clk = 1'b0;
        forever #5 ser_clk = ~ser_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[r].push_back(b);
        exp_q[r].push_back(b);
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0 || exp_q[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] pack_tx();
        logic [63:0] v = '0;
        foreach (tx_log[i]) v = {v[55:0], tx_log[i]};
        return v;
    endfunction

    function automatic logic [63:0] pack_grants();
        logic [63:0] v = '0;
        foreach (grant_log[i]) v = {v[55:0], 8'(grant_log[i])};
        return v;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        tx_log.delete();
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((pending() || m_owner >= 0) && n < budget) begin
            @(posedge ser_clk);
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
        repeat (3) @(posedge ser_clk);
    endtask

    // UART side: tx_cts pattern selected by cts_mode, tx_idle random.
    initial begin
        tx_cts  = 1'b0;
        tx_idle = 1'b1;
        forever begin
            @(posedge ser_clk);
            #1;
            cyc++;
            case (cts_mode)
                0: tx_cts = 1'($urandom_range(0, 1));
                1: tx_cts = ((cyc % 40) == 0);
                2: tx_cts = 1'b0;
                default: tx_cts = 1'b1;
            endcase
            tx_idle = 1'($urandom_range(0, 1));
        end
    end

    // Requester side: present queue heads, hold them until accepted.
    initial begin
        beat_t b;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge ser_clk);
            acc = req_valid & req_ready;
            @(posedge ser_clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
                if (src_q[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (req_valid[i]) begin
                    req_data[8*i +: 8] = src_q[i][0].data;
                    req_last[i]        = src_q[i][0].last;
                end
            end
        end
    end

    // Monitor: reference model of grant ownership plus per-requester scoreboards.
    always @(negedge ser_clk) begin
        logic               e_gv;
        logic               e_req;
        logic [7:0]         e_data;
        logic [NUM_REQ-1:0] e_rdy;
        logic [IDW-1:0]     e_gid;
        logic [IDW-1:0]     a_gid;
        beat_t              b;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = NUM_REQ - 1;
            m_hdr   = 1'b0;
            m_cnt   = 0;
        end else begin
            e_gv   = (m_owner >= 0);
            e_gid  = e_gv ? IDW'(m_owner) : '0;
            a_gid  = e_gv ? grant_id : '0;
            e_req  = 1'b0;
            e_data = 8'h00;
            e_rdy  = '0;
            if (e_gv && m_hdr) begin
                e_req  = 1'b1;
                e_data = 8'hA0 | 8'(m_owner);
            end else if (e_gv) begin
                e_req = req_valid[m_owner];
                if (e_req && exp_q[m_owner].size() > 0) e_data = exp_q[m_owner][0].data;
                e_rdy[m_owner] = tx_cts;
            end
            check("grant", {grant_valid, a_gid, busy}, {e_gv, e_gid, e_gv || !tx_idle});
            check("tx", {tx_req, tx_data, req_ready}, {e_req, e_data, e_rdy});
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
            if (m_owner < 0) begin
                if (|req_valid) begin
                    m_owner = rr_pick(m_last, req_valid);
                    m_cnt   = 0;
                    m_hdr   = HDR_EN;
                    grant_log.push_back(m_owner);
                end
            end else if (m_hdr) begin
                if (tx_cts) begin
                    m_hdr = 1'b0;
                    tx_log.push_back(tx_data);
                end
            end else if (req_valid[m_owner] && tx_cts) begin
                check("sb_avail", 64'(exp_q[m_owner].size() != 0), 64'd1);
                if (exp_q[m_owner].size() != 0) begin
                    b = exp_q[m_owner].pop_front();
                    check("sb_data", tx_data, b.data);
                    tx_log.push_back(tx_data);
                    m_cnt++;
                    if (b.last || m_cnt == MAX_LEN) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge ser_clk);
        #2;
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, !tx_idle);
        rst_n = 1'b1;

        // Two requesters valid from reset: 0 first, then 2.
        clear_logs();
        cts_mode = 0;
        push_byte(0, 8'hA1, 1'b0);
        push_byte(0, 8'hA2, 1'b1);
        push_byte(2, 8'hC1, 1'b0);
        push_byte(2, 8'hC2, 1'b1);
        drain("t2_drain", 2000);
        check("t2_grant_order", pack_grants(), 64'h0002);
        check("t2_tx_seq", pack_tx(), HDR_EN ? 64'hA0A1A2A2C1C2 : 64'hA1A2C1C2);

        // Three-byte packet with a slow clear-to-send.
        clear_logs();
        cts_mode = 1;
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        drain("t1_drain", 2000);
        check("t1_ready_cycles", rdy_cnt[0], 3);
        check("t1_tx_seq", pack_tx(), HDR_EN ? 64'hA0112233 : 64'h112233);

        // Length cap: 70 bytes from requester 1 with requester 3 waiting.
        clear_logs();
        cts_mode = 3;
        for (int i = 0; i < 70; i++) push_byte(1, 8'(i), i == 69);
        n = 0;
        while (m_owner != 1 && n < 50) begin
            @(posedge ser_clk);
            n++;
        end
        check("t3_grant1_seen", 64'(n < 50), 64'd1);
        for (int i = 0; i < 3; i++) push_byte(3, 8'hD0 + 8'(i), i == 2);
        drain("t3_drain", 2000);
        check("t3_grant_order", pack_grants(), 64'h010301);

        // Clear-to-send held low mid-grant.
        cts_mode = 2;
        for (int i = 0; i < 4; i++) push_byte(2, 8'h40 + 8'(i), i == 3);
        repeat (100) @(posedge ser_clk);
        check("t4_no_consume", src_q[2].size(), 4);
        check("t4_grant_held", {grant_valid, grant_id}, {1'b1, 2'd2});
        cts_mode = 3;
        drain("t4_drain", 2000);

        // Reset in the middle of a packet.
        for (int i = 0; i < 5; i++) push_byte(1, 8'hE1 + 8'(i), i == 4);
        n = 0;
        do begin
            @(posedge ser_clk);
            #2;
            n++;
        end while (!(m_owner == 1 && src_q[1].size() == 3) && n < 200);
        check("t5_mid_packet", 64'(n < 200), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_grant_valid", grant_valid, 0);
        check("t5_async_tx_req", tx_req, 0);
        check("t5_async_req_ready", req_ready, 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        push_byte(3, 8'h3A, 1'b1);
        push_byte(0, 8'h0A, 1'b1);
        repeat (3) @(posedge ser_clk);
        #2;
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge ser_clk);
            n++;
        end while (!grant_valid && n < 50);
        check("t5_regrant", grant_valid, 1);
        check("t5_first_after_reset", grant_id, 0);
        drain("t5_drain", 2000);

        // Single-byte packet (header framing when enabled).
        clear_logs();
        cts_mode = 0;
        push_byte(2, 8'h55, 1'b1);
        drain("t6_drain", 2000);
        check("t6_ready_cycles", rdy_cnt[2], 1);
        check("t6_tx_seq", pack_tx(), HDR_EN ? 64'hA255 : 64'h55);

        // Randomized traffic with valid gaps and random clear-to-send.
        gap_en   = 1'b1;
        cts_mode = 0;
        for (int p = 0; p < 60; p++) begin
            int r;
            int len;
            r   = $urandom_range(0, NUM_REQ - 1);
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) push_byte(r, 8'($urandom_range(0, 255)), i == len - 1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) @(posedge ser_clk);
        end
        drain("rand_drain", 20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Packet-level round-robin arbiter that shares one uart_tx transmitter among NUM_REQ byte-stream requesters.
- Sits between client logic (debug console, status reporters, trace dump) and uart_tx.
- Drives uart_tx's tx_data/tx_req and consumes its tx_cts/tx_idle.
- Once granted, a requester keeps the UART until its packet ends or a length cap fires, so bytes from different clients never interleave.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- MAX_LEN, 64, maximum bytes per grant before forced release; 1..255.

Ports:
- ser_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
- req_last  in  NUM_REQ  per-requester last byte of packet
- req_ready  out  NUM_REQ  per-requester byte accepted this cycle
- tx_data  out  8  byte to uart_tx
- tx_req  out  1  transmit request to uart_tx
- tx_cts  in  1  uart_tx clear-to-send; byte accepted when tx_req && tx_cts
- tx_idle  in  1  uart_tx line idle
- grant_valid  out  1  a requester currently owns the UART
- grant_id  out  clog2(NUM_REQ)  owning requester, valid when grant_valid
- busy  out  1  grant_valid || !tx_idle

Behaviour:
- Reset (async): state=IDLE, last_grant=NUM_REQ-1, byte_cnt=0. Outputs: tx_req=0, tx_data=0, req_ready=0, grant_valid=0, grant_id=0. busy=!tx_idle. Reset mid-packet drops the grant immediately; uart_tx finishes its current frame on its own.
- States: IDLE, SEND (plus HDR, see Optional Feature).
- IDLE:
  - If any req_valid is high, register grant_id = first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Clear byte_cnt and go to SEND (or HDR).
  - Arbitration costs one cycle. No tx_req in IDLE.
- SEND:
  - Combinational: tx_data = req_data[grant_id]; tx_req = req_valid[grant_id]; req_ready[grant_id] = tx_cts; all other req_ready=0.
  - When tx_req is low, tx_data=0.
  - On an accepted byte (req_valid[grant_id] && tx_cts): byte_cnt += 1.
  - If req_last=1 or byte_cnt+1 == MAX_LEN: go to IDLE and set last_grant=grant_id.
  - A valid drop mid-packet keeps the grant; there is no timeout.
- grant_valid=1 in SEND/HDR, 0 in IDLE.
- Back-to-back: after release, IDLE re-arbitrates next cycle. The same requester may win again only if no other requester is valid.
- byte_cnt is 8 bits. MAX_LEN=1 releases after every byte.
- Requesters must hold req_data/req_last stable while req_valid=1 && !req_ready; the arbiter does not register them.
- Simultaneous release and new requests: release takes effect at the clock edge; the new winner is chosen in the following IDLE cycle using the updated last_grant.

Optional Feature:
- Macro: UART_TX_ARB_HEADER_EN.
- Defined:
  - IDLE goes to HDR instead of SEND.
  - HDR drives tx_req=1 and tx_data={4'hA, 4'(grant_id)}, with all req_ready=0.
  - On tx_cts, go to SEND.
  - The header does not count toward MAX_LEN.
  - A forced MAX_LEN release followed by re-grant emits a fresh header.
- Undefined: HDR state is absent and IDLE goes directly to SEND; behaviour is otherwise identical.

Test Plan:
- Requester 0 sends 0x11,0x22,0x33 (last on 0x33), tx_cts pulsing every 40 cycles -> tx_data sequence 11,22,33; req_ready[0] high exactly 3 cycles; grant_valid falls the cycle after 0x33 is accepted.
- Requesters 0 and 2 both valid from reset with 2-byte packets -> req 0 served fully, then req 2; no interleave; grant_id 0 then 2.
- Requester 1 streams 70 bytes with no last, MAX_LEN=64, requester 3 waiting -> release after byte 64; requester 3 packet sent; requester 1 re-granted for the remaining 6.
- tx_cts held low 100 cycles during SEND -> tx_req=1, req_ready all 0, tx_data stable, no byte_cnt change.
- Assert rst_n low mid-packet (byte 2 of 5) -> grant_valid=0, tx_req=0 asynchronously; after release of reset with requester 3 valid, requester 0 has priority if also valid.
- With UART_TX_ARB_HEADER_EN, requester 2 sends 0x55 (last) -> tx_data sequence 0xA2, 0x55; req_ready[2] high only on the second accepted byte.
